// File: rtl/de0_rstseq_pkg.sv
// ---------------------------------------------------------------------------
// de0_rstseq_pkg
// Shared types for the DE0 reset sequencer: the 2-bit state encoding, which
// also drives the debug LEDs, and a small integer helper used to size the
// shared sequencing counter.
// ---------------------------------------------------------------------------
package de0_rstseq_pkg;

    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        LOCKWAIT = 2'd1,
        SYSUP    = 2'd2,
        RUN      = 2'd3
    } rstseq_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/de0_debounce.sv
// ---------------------------------------------------------------------------
// de0_debounce
// Synchronizes an asynchronous, bouncy key input into the clk domain and
// debounces it. The output only changes after the synchronized input has
// disagreed with it for BTN_CYCLES consecutive cycles. Synchronizer and
// output come out of reset at 1 (key released for an active-low key), so
// the block suits any of the board keys.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth (>= 2)
//   BTN_CYCLES   debounce window in clk cycles (>= 2)
// Ports:
//   clk   in   system clock
//   rst   in   synchronous active-high reset
//   din   in   raw key level, asynchronous
//   dout  out  debounced key level
// ---------------------------------------------------------------------------
module de0_debounce #(
    parameter int SYNC_STAGES = 2,
    parameter int BTN_CYCLES  = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int            CW       = $clog2(BTN_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BTN_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   deb_q;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];
    assign dout   = deb_q;

    // Plain shift-register synchronizer; it resets to the released level so
    // the debouncer does not see a phantom press after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    // The counter measures how long the synchronized key has disagreed with
    // the debounced value. Any agreement restarts the window, so a bounce
    // shorter than BTN_CYCLES never reaches the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            deb_q <= 1'b1;
        end else if (synced == deb_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
            deb_q <= synced;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/de0_rstseq.sv
// ---------------------------------------------------------------------------
// de0_rstseq
// Reset sequencer for the DE0 board, clocked by the 25 MHz PLL output.
// Waits for a stable PLL lock, releases sys_rst (bus, video, memory), then
// after a further delay releases cpu_rst (Z80). Lock loss or a debounced
// key press drops everything back into reset and the sequence reruns.
//
// Parameters:
//   SYNC_STAGES  synchronizer depth for pll_locked and btn_n (>= 2)
//   LOCK_CYCLES  consecutive lock cycles before sys_rst release (>= 2)
//   CPU_DELAY    cycles from sys_rst release to cpu_rst release (>= 1)
//   BTN_CYCLES   key debounce window in clk cycles (>= 2)
//   WDT_CYCLES   watchdog timeout in RUN (only with RSTSEQ_WDT_EN)
// Ports:
//   clk         in   system clock (m25)
//   rst         in   synchronous active-high reset
//   pll_locked  in   PLL lock flag, asynchronous
//   btn_n       in   reset key, active-low, asynchronous, bouncy
//   wdt_kick    in   watchdog kick (only with RSTSEQ_WDT_EN)
//   wdt_fired   out  sticky watchdog flag (only with RSTSEQ_WDT_EN)
//   sys_rst     out  active-high reset for bus, video, memory
//   cpu_rst     out  active-high reset for the Z80 core
//   ready       out  high only in RUN
//   state       out  current FSM state for the debug LEDs
//
// Build option: define RSTSEQ_WDT_EN to add a CPU watchdog that, on timeout
// in RUN, drops back to SYSUP so only the CPU is reset again.
// ---------------------------------------------------------------------------
module de0_rstseq
    import de0_rstseq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int CPU_DELAY   = 16,
    parameter int BTN_CYCLES  = 250000
`ifdef RSTSEQ_WDT_EN
    ,
    parameter int WDT_CYCLES  = 1 << 24
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       btn_n,
`ifdef RSTSEQ_WDT_EN
    input  logic       wdt_kick,
    output logic       wdt_fired,
`endif
    output logic       sys_rst,
    output logic       cpu_rst,
    output logic       ready,
    output logic [1:0] state
);

    localparam int                CNT_W     = $clog2(max_int(LOCK_CYCLES, CPU_DELAY));
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CPU_LAST  = CNT_W'(CPU_DELAY - 1);

    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   lock_s;
    logic                   key_deb;
    logic                   pressed;
    logic                   abort;

    rstseq_state_e          state_q;
    rstseq_state_e          state_n;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_n;

    logic                   sys_rst_q;
    logic                   cpu_rst_q;
    logic                   ready_q;

    assign lock_s  = lock_sync_q[SYNC_STAGES-1];
    assign pressed = ~key_deb;
    assign abort   = ~lock_s | pressed;

    assign sys_rst = sys_rst_q;
    assign cpu_rst = cpu_rst_q;
    assign ready   = ready_q;
    assign state   = state_q;

    // The lock synchronizer clears to 0 so that a reset always forces the
    // full lock qualification to run again.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_sync_q <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    de0_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .BTN_CYCLES  (BTN_CYCLES)
    ) u_key (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_n),
        .dout (key_deb)
    );

`ifdef RSTSEQ_WDT_EN
    localparam int               WDT_W    = $clog2(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_cnt_q;
    logic             wdt_fired_q;
    logic             wdt_expire;

    assign wdt_expire = (state_q == RUN) && !wdt_kick && (wdt_cnt_q == WDT_LAST);
    assign wdt_fired  = wdt_fired_q;

    // The watchdog only runs while the CPU is out of reset. A kick in the
    // expiry cycle still rescues the CPU. The fired flag is set only when
    // the timeout actually causes the SYSUP fallback, i.e. not when a lock
    // loss or key press wins in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wdt_cnt_q   <= '0;
            wdt_fired_q <= 1'b0;
        end else begin
            if ((state_q != RUN) || (state_n != RUN) || wdt_kick) begin
                wdt_cnt_q <= '0;
            end else begin
                wdt_cnt_q <= wdt_cnt_q + WDT_W'(1);
            end
            if ((state_q == RUN) && (state_n == SYSUP)) begin
                wdt_fired_q <= 1'b1;
            end
        end
    end
`endif

    // State register and the shared sequencing counter. The reset outputs
    // are registered from the next-state decode so they change on the same
    // edge as the state and never glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= HOLD;
            cnt_q     <= '0;
            sys_rst_q <= 1'b1;
            cpu_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            sys_rst_q <= (state_n == HOLD) || (state_n == LOCKWAIT);
            cpu_rst_q <= (state_n != RUN);
            ready_q   <= (state_n == RUN);
        end
    end

    // Next-state decode. Lock loss and key press share one abort term, so
    // both arriving together still give a single HOLD entry. The counter is
    // reused: LOCKWAIT counts lock cycles, SYSUP counts the CPU delay.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        unique case (state_q)
            HOLD: begin
                if (!abort) begin
                    state_n = LOCKWAIT;
                    cnt_n   = '0;
                end
            end
            LOCKWAIT: begin
                if (abort) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (cnt_q == LOCK_LAST) begin
                    state_n = SYSUP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            SYSUP: begin
                if (abort) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (cnt_q == CPU_LAST) begin
                    state_n = RUN;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = HOLD;
                    cnt_n   = '0;
`ifdef RSTSEQ_WDT_EN
                end else if (wdt_expire) begin
                    state_n = SYSUP;
                    cnt_n   = '0;
`endif
                end
            end
            default: begin
                state_n = HOLD;
                cnt_n   = '0;
            end
        endcase
    end

endmodule
